// File: rtl/puneh_mem_loader.sv
// -----------------------------------------------------------------------------
// puneh_mem_loader
//
// Word-addressed program/data memory for the PUNEH core. It also runs the boot
// sequence. After reset the array is zero-filled. A program image is then
// accepted as a byte stream, high byte first. When the image is complete, the
// core is released from reset and the array serves the core's memory bus.
//
// Parameters
//   ADDR_W      implemented word-address bits (depth = 2^ADDR_W 16-bit words)
//
// Ports
//   clk         system clock; all state updates on its rising edge
//   rst         synchronous active-high reset; restarts the boot sequence
//   loadValid   loader byte valid
//   loadByte    loader byte
//   loadLast    final word of the image; only looked at with a low byte
//   loadReady   loader may transfer this cycle (LOAD_HI / LOAD_LO)
//   readMEM     core read request
//   writeMEM    core write request
//   addrBus     core word address
//   dataBusOut  core write data
//   dataBusIn   read data to core (combinational, 0 when not serving a read)
//   cpuRst      reset to the core; high until boot completes
//   loadDone    high once the image is loaded (RUN)
//   wordCount   number of image words loaded
//   addrErr     sticky flag: core touched an address outside the array
// -----------------------------------------------------------------------------
module puneh_mem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loadValid,
  input  logic [7:0]        loadByte,
  input  logic              loadLast,
  output logic              loadReady,
  input  logic              readMEM,
  input  logic              writeMEM,
  input  logic [15:0]       addrBus,
  input  logic [15:0]       dataBusOut,
  output logic [15:0]       dataBusIn,
  output logic              cpuRst,
  output logic              loadDone,
  output logic [ADDR_W:0]   wordCount,
  output logic              addrErr
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] ST_CLEAR   = 2'd0;
  localparam logic [1:0] ST_LOAD_HI = 2'd1;
  localparam logic [1:0] ST_LOAD_LO = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] clr_ptr_q,  clr_ptr_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [7:0]        hi_byte_q,  hi_byte_d;
  logic              addr_err_q, addr_err_d;

  logic [15:0]       mem_q [DEPTH];

  logic              xfer_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] core_addr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [15:0]       mem_wdata_s;

  // Loader handshake and core address decode.
  always_comb begin
    loadReady   = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
    xfer_s      = loadValid && loadReady;
    // A shift keeps the in-range test valid even when ADDR_W reaches 16.
    in_range_s  = ((addrBus >> ADDR_W) == 16'd0);
    core_addr_s = addrBus[ADDR_W-1:0];
  end

  // Select the single array write port user: clear, image load or core write.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = clr_ptr_q;
    mem_wdata_s = 16'h0000;
    case (state_q)
      ST_CLEAR: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_ptr_q;
        mem_wdata_s = 16'h0000;
      end
      ST_LOAD_LO: begin
        mem_we_s    = xfer_s;
        mem_waddr_s = ptr_q;
        mem_wdata_s = {hi_byte_q, loadByte};
      end
      ST_RUN: begin
        mem_we_s    = writeMEM && in_range_s;
        mem_waddr_s = core_addr_s;
        mem_wdata_s = dataBusOut;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_ptr_q;
        mem_wdata_s = 16'h0000;
      end
    endcase
  end

  // Boot sequencer next-state logic.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ptr_d      = ptr_q;
    word_cnt_d = word_cnt_q;
    hi_byte_d  = hi_byte_q;
    addr_err_d = addr_err_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + PTR_ONE;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_LOAD_HI;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_LOAD_HI: begin
        if (xfer_s) begin
          hi_byte_d = loadByte;
          state_d   = ST_LOAD_LO;
        end else begin
          state_d   = ST_LOAD_HI;
        end
      end
      ST_LOAD_LO: begin
        if (xfer_s) begin
          ptr_d      = ptr_q + PTR_ONE;
          word_cnt_d = word_cnt_q + CNT_ONE;
          // A full array ends the image even without loadLast.
          if (loadLast || (ptr_q == LAST_ADDR)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD_HI;
          end
        end else begin
          state_d = ST_LOAD_LO;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        if ((readMEM || writeMEM) && !in_range_s) begin
          addr_err_d = 1'b1;
        end else begin
          addr_err_d = addr_err_q;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_ptr_q  <= {ADDR_W{1'b0}};
      ptr_q      <= {ADDR_W{1'b0}};
      word_cnt_q <= {(ADDR_W+1){1'b0}};
      hi_byte_q  <= 8'h00;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
      hi_byte_q  <= hi_byte_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Memory array. It is not reset directly, because CLEAR zero-fills it after
  // every reset. Writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end else begin
      mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
    end
  end

  // Core-facing outputs. Reads are combinational, so a same-cycle write still
  // returns the old word.
  always_comb begin
    cpuRst    = (state_q != ST_RUN);
    loadDone  = (state_q == ST_RUN);
    wordCount = word_cnt_q;
    addrErr   = addr_err_q;
    if ((state_q == ST_RUN) && readMEM && in_range_s) begin
      dataBusIn = mem_q[core_addr_s];
    end else begin
      dataBusIn = 16'h0000;
    end
  end

endmodule

// File: tb/tb_puneh_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_puneh_mem_loader
//
// Directed bench for puneh_mem_loader (ADDR_W = 8). A reference model tracks
// the boot phase, image words, memory contents and error flag. A compare
// process checks every DUT output against the model on each falling edge.
// Literal checks in the stimulus pin the model to hand-worked values.
// -----------------------------------------------------------------------------
module tb_puneh_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadValid;
  logic [7:0]  loadByte;
  logic        loadLast;
  logic        loadReady;
  logic        readMEM;
  logic        writeMEM;
  logic [15:0] addrBus;
  logic [15:0] dataBusOut;
  logic [15:0] dataBusIn;
  logic        cpuRst;
  logic        loadDone;
  logic [8:0]  wordCount;
  logic        addrErr;

  int n_checks = 0;
  int n_fail   = 0;

  puneh_mem_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .loadValid  (loadValid),
    .loadByte   (loadByte),
    .loadLast   (loadLast),
    .loadReady  (loadReady),
    .readMEM    (readMEM),
    .writeMEM   (writeMEM),
    .addrBus    (addrBus),
    .dataBusOut (dataBusOut),
    .dataBusIn  (dataBusIn),
    .cpuRst     (cpuRst),
    .loadDone   (loadDone),
    .wordCount  (wordCount),
    .addrErr    (addrErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 1'b0;
  int          m_clr;
  bit          m_lo, m_done, m_err;
  logic [7:0]  m_hi;
  int          m_n;
  logic [15:0] m_mem [256];

  // Model: advance one clock using the inputs present at this edge.
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_clr = 256; m_lo = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_hi = 8'h00; m_n = 0;
      foreach (m_mem[k]) m_mem[k] = 16'h0000;
    end else if (m_clr > 0) begin
      m_clr--;
    end else if (!m_done) begin
      if (loadValid) begin
        if (!m_lo) begin
          m_hi = loadByte; m_lo = 1'b1;
        end else begin
          m_mem[m_n] = {m_hi, loadByte};
          m_n++;
          m_lo = 1'b0;
          if (loadLast || m_n == 256) m_done = 1'b1;
        end
      end
    end else begin
      if ((readMEM || writeMEM) && addrBus >= 16'd256) m_err = 1'b1;
      if (writeMEM && addrBus < 16'd256) m_mem[addrBus[7:0]] = dataBusOut;
    end
  end

  // Compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("loadReady", loadReady, (m_clr == 0 && !m_done) ? 32'd1 : 32'd0);
      chk("cpuRst",    cpuRst,    m_done ? 32'd0 : 32'd1);
      chk("loadDone",  loadDone,  m_done ? 32'd1 : 32'd0);
      chk("wordCount", wordCount, m_n);
      chk("addrErr",   addrErr,   m_err ? 32'd1 : 32'd0);
      chk("dataBusIn", dataBusIn,
          (m_done && readMEM && addrBus < 16'd256) ? {16'h0000, m_mem[addrBus[7:0]]} : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    loadValid = 1'b1; loadByte = b; loadLast = last;
    tick();
    loadValid = 1'b0; loadLast = 1'b0;
  endtask

  task automatic rd(input string name, input logic [15:0] a, input logic [15:0] exp);
    readMEM = 1'b1; addrBus = a;
    #1;
    chk(name, dataBusIn, exp);
  endtask

  task automatic scan_all();
    for (int a = 0; a < 256; a++) begin
      readMEM = 1'b1; addrBus = 16'(a);
      tick();
    end
    readMEM = 1'b0;
  endtask

  task automatic reboot();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cpuRst", cpuRst, 32'd1);
    chk("rst_loadReady", loadReady, 32'd0);
    chk("rst_wordCount", wordCount, 32'd0);
    repeat (256) tick();
    chk("clear_done_ready", loadReady, 32'd1);
  endtask

  // Bound the whole run.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected end within 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; loadValid = 1'b0; loadByte = 8'h00; loadLast = 1'b0;
    readMEM = 1'b0; writeMEM = 1'b0; addrBus = 16'h0000; dataBusOut = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_cpuRst", cpuRst, 32'd1);
    chk("reset_addrErr", addrErr, 32'd0);

    // CLEAR lasts 256 cycles; reads during boot return 0.
    readMEM = 1'b1; addrBus = 16'h0001;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      chk("clear_ready_timing", loadReady, (i == 256) ? 32'd1 : 32'd0);
      chk("clear_cpuRst", cpuRst, 32'd1);
    end
    tick();
    readMEM = 1'b0;

    // Two-word image.
    send(8'h12, 1'b1);  // loadLast ignored on a high byte
    send(8'h34, 1'b0);
    send(8'hAB, 1'b0);
    chk("before_last_cpuRst", cpuRst, 32'd1);
    send(8'hCD, 1'b1);
    chk("img_cpuRst", cpuRst, 32'd0);
    chk("img_loadDone", loadDone, 32'd1);
    chk("img_wordCount", wordCount, 32'd2);
    rd("img_mem0", 16'h0000, 16'h1234);
    rd("img_mem1", 16'h0001, 16'hABCD);
    tick();

    // Simultaneous write and read at one address.
    writeMEM = 1'b1; dataBusOut = 16'hBEEF;
    rd("rw_same_cycle_old", 16'h0005, 16'h0000);
    tick();
    writeMEM = 1'b0;
    rd("rw_next_cycle_new", 16'h0005, 16'hBEEF);
    tick();

    // Out-of-range accesses.
    rd("oor_read_zero", 16'h0100, 16'h0000);
    tick();
    readMEM = 1'b0;
    chk("oor_addrErr", addrErr, 32'd1);
    writeMEM = 1'b1; addrBus = 16'h0100; dataBusOut = 16'hDEAD;
    tick();
    writeMEM = 1'b0;
    rd("oor_keep_mem0", 16'h0000, 16'h1234);
    chk("oor_addrErr_sticky", addrErr, 32'd1);
    scan_all();

    // Stall between bytes, then reset in the middle of a word.
    reboot();
    chk("reboot_addrErr_clr", addrErr, 32'd0);
    send(8'h55, 1'b0);
    repeat (10) tick();
    send(8'h66, 1'b0);
    chk("stall_wordCount", wordCount, 32'd1);
    loadValid = 1'b1; loadByte = 8'h77; rst = 1'b1;
    tick();
    loadValid = 1'b0; rst = 1'b0;
    chk("midload_cpuRst", cpuRst, 32'd1);
    chk("midload_ready", loadReady, 32'd0);
    repeat (256) tick();

    // One-word image with a stall between its two bytes.
    send(8'h99, 1'b0);
    repeat (10) tick();
    chk("stall_hold_ready", loadReady, 32'd1);
    chk("stall_hold_cpuRst", cpuRst, 32'd1);
    send(8'h11, 1'b1);
    chk("oneword_done", loadDone, 32'd1);
    chk("oneword_count", wordCount, 32'd1);
    rd("oneword_mem0", 16'h0000, 16'h9911);
    rd("rezero_mem1", 16'h0001, 16'h0000);
    rd("rezero_mem5", 16'h0005, 16'h0000);
    readMEM = 1'b0;
    send(8'hEE, 1'b1);   // dropped in RUN
    rd("drop_mem1", 16'h0001, 16'h0000);
    tick();
    readMEM = 1'b0;

    // Fill the whole array without loadLast.
    reboot();
    for (int i = 0; i < 512; i++) begin
      loadValid = 1'b1; loadByte = 8'(i * 7 + 3);
      tick();
    end
    chk("full_wordCount", wordCount, 32'd256);
    chk("full_done", loadDone, 32'd1);
    chk("full_ready", loadReady, 32'd0);
    repeat (3) tick();
    loadValid = 1'b0;
    rd("full_mem0", 16'h0000, 16'h030A);
    rd("full_mem255", 16'h00FF, 16'hF5FC);
    scan_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
